// File: rtl/sample_iterator.sv
// Bounding-box sample iterator: latches one triangle and walks its sample box in raster order.
// Optional performance counters are enabled with `define SAMPLE_ITER_PERF_EN.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]           color_R14U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]             box_R14S,
  input  logic                                          validTri_R14H,
  input  logic        [1:0]                              ss_w_lg2_R14U,
  output logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]           color_R16U,
  output logic signed [1:0][SIGFIG-1:0]                  sample_R16S,
  output logic                                          validSamp_R16H,
  output logic                                          state_dbg
`ifdef SAMPLE_ITER_PERF_EN
  ,
  output logic [31:0]                                   tri_cnt_R16U,
  output logic [31:0]                                   samp_cnt_R16U
`endif
);

  // valid/ready: a triangle transfers on a rising edge where validTri_R14H=1 and
  // halt_RnnnnL=1; while halt_RnnnnL=0 upstream holds its inputs stable.
  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  state_t                                  state_q, state_n;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_q, tri_n;
  logic [COLORS-1:0][SIGFIG-1:0]           color_q, color_n;
  logic [1:0][SIGFIG-1:0]                  ll_q, ll_n, ur_q, ur_n, samp_q, samp_n;
  logic [SIGFIG-1:0]                       step_q, step_n, step_in;
  logic [1:0]                              ss_eff;
  logic                                    box_ok;
  logic signed [SIGFIG:0]                  x_adv, y_adv, urx_ext, ury_ext;

  assign ss_eff  = (ss_w_lg2_R14U == 2'd3) ? 2'd2 : ss_w_lg2_R14U;
  assign step_in = SIGFIG'(1) << (RADIX - int'(ss_eff));
  assign box_ok  = ($signed(box_R14S[1][0]) >= $signed(box_R14S[0][0])) &&
                   ($signed(box_R14S[1][1]) >= $signed(box_R14S[0][1]));

  // One extra bit keeps x+step from wrapping past the positive limit.
  assign x_adv   = $signed({samp_q[0][SIGFIG-1], samp_q[0]}) + $signed({1'b0, step_q});
  assign y_adv   = $signed({samp_q[1][SIGFIG-1], samp_q[1]}) + $signed({1'b0, step_q});
  assign urx_ext = $signed({ur_q[0][SIGFIG-1], ur_q[0]});
  assign ury_ext = $signed({ur_q[1][SIGFIG-1], ur_q[1]});

  always_comb begin
    state_n = state_q;
    tri_n   = tri_q;
    color_n = color_q;
    ll_n    = ll_q;
    ur_n    = ur_q;
    step_n  = step_q;
    samp_n  = samp_q;
    case (state_q)
      WAIT: begin
        if (validTri_R14H && box_ok) begin
          state_n = TEST;
          tri_n   = tri_R14S;
          color_n = color_R14U;
          ll_n    = box_R14S[0];
          ur_n    = box_R14S[1];
          step_n  = step_in;
          samp_n  = box_R14S[0];
        end
      end
      TEST: begin
        if (x_adv <= urx_ext) begin
          samp_n[0] = x_adv[SIGFIG-1:0];
        end else if (y_adv <= ury_ext) begin
          samp_n[0] = ll_q[0];
          samp_n[1] = y_adv[SIGFIG-1:0];
        end else begin
          state_n = WAIT;
        end
      end
      default: state_n = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      tri_q   <= '0;
      color_q <= '0;
      ll_q    <= '0;
      ur_q    <= '0;
      step_q  <= '0;
      samp_q  <= '0;
    end else begin
      state_q <= state_n;
      tri_q   <= tri_n;
      color_q <= color_n;
      ll_q    <= ll_n;
      ur_q    <= ur_n;
      step_q  <= step_n;
      samp_q  <= samp_n;
    end
  end

  assign halt_RnnnnL    = (state_q == WAIT);
  assign validSamp_R16H = (state_q == TEST);
  assign state_dbg      = state_q;
  assign tri_R16S       = tri_q;
  assign color_R16U     = color_q;
  assign sample_R16S    = samp_q;

`ifdef SAMPLE_ITER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_cnt_R16U  <= '0;
      samp_cnt_R16U <= '0;
    end else begin
      if (state_q == WAIT && validTri_R14H && box_ok) tri_cnt_R16U <= tri_cnt_R16U + 32'd1;
      if (state_q == TEST) samp_cnt_R16U <= samp_cnt_R16U + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sample_iterator.md
# sample_iterator

Bounding-box sample iterator that sits directly upstream of the sample test stage. It accepts one triangle with its sample-aligned bounding box from the bounding-box stage. It walks every subsample location in that box in raster order, one per cycle, and presents each sample with the triangle and colour. It stalls the bounding-box stage with an active-low halt while a box is being walked.

## Interface
- SIGFIG, 24, bits in colour and position
- RADIX, 10, fraction bits in colour and position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, colour channels

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- tri_R14S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle from bounding-box stage
- color_R14U  in  unsigned [SIGFIG-1:0] [COLORS]  triangle colour
- box_R14S  in  signed [SIGFIG-1:0] [2][2]  box; [0]=lower-left, [1]=upper-right, [.][0]=x, [.][1]=y; sample-grid aligned
- validTri_R14H  in  1  box/triangle valid; held stable by upstream while halt_RnnnnL is low
- ss_w_lg2_R14U  in  2  log2 subsamples per pixel axis (0..2); 3 treated as 2
- halt_RnnnnL  out  1  high = ready to accept; low = upstream must hold
- tri_R16S, color_R16U  out  same widths  latched triangle and colour
- sample_R16S  out  signed [SIGFIG-1:0] [2]  current sample (x,y)
- validSamp_R16H  out  1  sample_R16S is a valid location

## Operation
- Step size is `step = 1 << (RADIX - ss_w_lg2)`. It is latched with the triangle.
- State WAIT:
  - halt_RnnnnL = 1.
  - If validTri_R14H=1 and the box is non-inverted (ur.x ≥ ll.x and ur.y ≥ ll.y):
    - latch tri, colour, box and step;
    - sample ← ll;
    - go to TEST.
  - An inverted box, or validTri_R14H=0, is dropped: state stays WAIT and no sample is emitted.
- State TEST:
  - validSamp_R16H = 1 and halt_RnnnnL = 0.
  - Each cycle the current sample is presented and then advanced:
    - if x+step ≤ ur.x: x ← x+step;
    - else if y+step ≤ ur.y: x ← ll.x, y ← y+step;
    - else (last sample): go to WAIT.
- Advance comparisons are done at SIGFIG+1 bits signed, so x+step never wraps near the positive limit.
- Outputs are registered directly from the state; there is no combinational path from inputs to outputs.
- tri_R16S and color_R16U hold their value while in WAIT; downstream qualifies them with validSamp_R16H.
- There is no downstream backpressure: the sample-test stage accepts one sample per cycle unconditionally.
- Reset (async, any state, including mid-box):
  - state=WAIT, halt_RnnnnL=1, validSamp_R16H=0;
  - sample, tri, colour, box and step registers = 0.
  - The partially walked box is discarded.

## Timing
- Triangle accepted at edge N (WAIT, validTri_R14H=1) → first sample valid after edge N, i.e. cycle N+1.
- A box of W×H samples gives validSamp_R16H high for exactly W·H consecutive cycles.
- After the last sample's edge, state=WAIT, halt_RnnnnL=1 and validSamp_R16H=0.
- The next triangle is accepted at the following edge. This gives exactly one bubble cycle between triangles.
- A 1×1 box is one TEST cycle.
- halt_RnnnnL falls in the same cycle validSamp_R16H rises and rises in the same cycle it falls.

## Configuration
- SAMPLE_ITER_PERF_EN:
  - Defined: adds outputs `tri_cnt_R16U[31:0]` (count of accepted triangles) and `samp_cnt_R16U[31:0]` (count of cycles with validSamp_R16H=1).
  - Both counters wrap at 2^32 and reset to 0.
  - Undefined: the ports and counters are absent and the remaining behaviour is identical.

## Test plan
- Basic walk:
  - Stimulus: ss=0, box ll(0,0) ur(2048,1024), one triangle.
  - Required response: samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles; halt_RnnnnL low for those 6 cycles, then high.
- Subsample step:
  - Stimulus: ss=2, box ll(512,512) ur(1280,768).
  - Required response: step 256; 4×2 = 8 samples, first (512,512), last (1280,768).
- Back-to-back and degenerate boxes:
  - Stimulus: validTri_R14H held high with two 1×1 boxes.
  - Required response: validSamp_R16H pattern 1,0,1; upstream holds the second triangle until halt_RnnnnL=1.
  - Stimulus: inverted box ll(1024,0) ur(0,0).
  - Required response: no validSamp_R16H and halt_RnnnnL stays 1.
- Reset mid-box:
  - Stimulus: assert rst asynchronously on the 3rd sample of the basic walk.
  - Required response: validSamp_R16H=0 and halt_RnnnnL=1 immediately; after release, a new box restarts from its own ll.
- Negative and near-limit coordinates:
  - Stimulus: box ll(-2048,-1024) ur(-1024,-1024), ss=0.
  - Required response: samples (-2048,-1024),(-1024,-1024).
  - Stimulus: ur.x = 2^23-1024, ss=0.
  - Required response: no wrap; the row ends at ur.x.
- With SAMPLE_ITER_PERF_EN:
  - Stimulus: run the basic walk plus a 1×1 box.
  - Required response: tri_cnt_R16U=2, samp_cnt_R16U=7.
